// File: rtl/dr_skew_sequencer.sv
// Skew sequencer: accepts a programmed number of LANES-wide vectors and issues lane k
// through a (k+1)-stage delay chain, then drains. Optional stall counter: DR_SKEW_STALL_CNT_EN.
module dr_skew_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int LEN_W = 8
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic [LANES*DW-1:0] lane_data,
  output logic [LANES-1:0]    lane_valid,
  output logic                busy,
`ifdef DR_SKEW_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic                done
);

  localparam int DCW = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [DCW-1:0]   drain_cnt, drain_cnt_nxt;
  logic             accept;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    drain_cnt_nxt = drain_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt     = S_LOAD;
            remaining_nxt = len;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = DCW'(LANES - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_nxt = S_DONE;
        else                 drain_cnt_nxt = drain_cnt - 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane k: k+1 stages. Non-accepted slots carry zero data so invalid lanes always read 0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] d_sr [k+1];
    logic          v_sr [k+1];

    // NOTE: the chain stages are cleared on reset so a discarded job never leaks onto the array.
    always_ff @(posedge clock) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) begin
          d_sr[j] <= '0;
          v_sr[j] <= 1'b0;
        end
      end else begin
        d_sr[0] <= accept ? in_data[k*DW +: DW] : '0;
        v_sr[0] <= accept;
        for (int j = 1; j <= k; j++) begin
          d_sr[j] <= d_sr[j-1];
          v_sr[j] <= v_sr[j-1];
        end
      end
    end

    assign lane_data[k*DW +: DW] = d_sr[k];
    assign lane_valid[k]         = v_sr[k];
  end

`ifdef DR_SKEW_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= '0;
    end else if ((state == S_LOAD) && !in_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dr_skew_sequencer.sv
// Bench for dr_skew_sequencer: directed vector table, hand-written corner sequences and
// randomized jobs checked against a cycle-schedule model built from the timing rules.
module tb_dr_skew_sequencer;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int LEN_W = 8;
  localparam int W     = LANES * DW;
  localparam int MAXC  = 512;

  logic             clock;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [W-1:0]     lane_data;
  logic [LANES-1:0] lane_valid;
  logic             busy;
  logic             done;
`ifdef DR_SKEW_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  dr_skew_sequencer #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W)) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy),
`ifdef DR_SKEW_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {in_ready, busy, done, lane_valid, lane_data}
  function automatic logic [38:0] outs_now();
    return {in_ready, busy, done, lane_valid, lane_data};
  endfunction

  function automatic logic [38:0] mk(input logic r, input logic b, input logic d,
                                     input logic [3:0] lv, input logic [31:0] ld);
    return {r, b, d, lv, ld};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic [38:0] exp;
  } vec_t;

  // One job from its start cycle (r=0) through its DONE cycle. mode 0: in_valid from
  // mask (1 beyond bit 31); mode 1: random in_valid at vpct percent plus stray start pulses.
  task automatic run_job(input string tag, input int jl, input int mode,
                         input logic [31:0] mask, input int vpct);
    logic        vld [MAXC];
    logic [31:0] dat [MAXC];
    logic        st  [MAXC];
    int          acc_cyc [256];
    logic [31:0] acc_vec [256];
    int acc, r, a_last, done_r, exp_stall;
    logic [3:0]  e_lv;
    logic [31:0] e_ld;

    for (int i = 0; i < MAXC; i++) begin
      dat[i] = $urandom();
      if (mode == 0) vld[i] = (i < 32) ? mask[i] : 1'b1;
      else           vld[i] = (i >= 200) ? 1'b1 : ($urandom_range(99) < vpct);
      st[i] = (mode == 1) && ($urandom_range(3) == 0);
    end

    // Accept schedule: LOAD begins at r=1 and ends with the jl-th valid cycle.
    acc = 0;
    r = 1;
    a_last = 0;
    exp_stall = 0;
    while (acc < jl) begin
      if (vld[r]) begin
        acc_cyc[acc] = r;
        acc_vec[acc] = dat[r];
        acc++;
        a_last = r;
      end else begin
        exp_stall++;
      end
      r++;
    end
    done_r = (jl == 0) ? 1 : a_last + LANES + 1;

    for (int c = 0; c <= done_r; c++) begin
      start    = (c == 0) ? 1'b1 : st[c];
      len      = (c == 0) ? LEN_W'(jl) : LEN_W'($urandom_range(255, 1));
      in_valid = vld[c];
      in_data  = dat[c];
      e_lv = '0;
      e_ld = '0;
      for (int k = 0; k < LANES; k++)
        for (int i = 0; i < jl; i++)
          if (acc_cyc[i] + k + 1 == c) begin
            e_lv[k]        = 1'b1;
            e_ld[k*DW +: DW] = acc_vec[i][k*DW +: DW];
          end
      @(negedge clock);
      check($sformatf("%s r=%0d", tag, c), outs_now(),
            mk((jl != 0) && (c >= 1) && (c <= a_last),
               (jl != 0) && (c >= 1) && (c <= a_last + LANES),
               c == done_r, e_lv, e_ld));
`ifdef DR_SKEW_STALL_CNT_EN
      if (c == done_r) check({tag, " stall_cnt"}, stall_cnt, exp_stall);
`endif
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 8'd3, 1'b1, 32'hDEADBEEF, mk(0, 0, 0, 4'b0000, 32'h0)};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 32'h04030201, mk(1, 1, 0, 4'b0000, 32'h0)};
    tbl[2] = '{1'b1, 8'd1, 1'b1, 32'h08070605, mk(1, 1, 0, 4'b0001, 32'h00000001)};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 32'h0C0B0A09, mk(1, 1, 0, 4'b0011, 32'h00000205)};
    tbl[4] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, mk(0, 1, 0, 4'b0111, 32'h00030609)};
    tbl[5] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, mk(0, 1, 0, 4'b1110, 32'h04070A00)};
    tbl[6] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, mk(0, 1, 0, 4'b1100, 32'h080B0000)};
    tbl[7] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, mk(0, 1, 0, 4'b1000, 32'h0C000000)};
    tbl[8] = '{1'b1, 8'd5, 1'b1, 32'hFFFFFFFF, mk(0, 0, 1, 4'b0000, 32'h0)};
    tbl[9] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, mk(0, 0, 0, 4'b0000, 32'h0)};

    // Reset with active-looking inputs: nothing may start.
    rst = 1'b1;
    start = 1'b1;
    len = 8'd3;
    in_valid = 1'b1;
    in_data = 32'hA5A5A5A5;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset outputs", outs_now(), '0);
`ifdef DR_SKEW_STALL_CNT_EN
    check("reset stall_cnt", stall_cnt, 16'd0);
`endif
    tick();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;

    // Full-throughput len=3 job, with start pulses in LOAD and DONE that must be ignored.
    for (int i = 0; i < 10; i++) begin
      start    = tbl[i].start;
      len      = tbl[i].len;
      in_valid = tbl[i].in_valid;
      in_data  = tbl[i].in_data;
      @(negedge clock);
      check($sformatf("tbl[%0d]", i), outs_now(), tbl[i].exp);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;

    // One-cycle bubble between vectors 1 and 2.
    run_job("bubble", 3, 0, 32'b11010, 100);
    // Empty job.
    run_job("len0", 0, 0, 32'hFFFFFFFF, 100);

    // Reset mid-LOAD after one of three accepts.
    start = 1'b1;
    len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11223344;
    @(negedge clock);
    check("midrst ready", in_ready, 1'b1);
    tick();
    rst = 1'b1;
    in_data = 32'h55667788;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("midrst quiet %0d", i), outs_now(), '0);
`ifdef DR_SKEW_STALL_CNT_EN
      if (i == 0) check("midrst stall_cnt", stall_cnt, 16'd0);
`endif
      tick();
    end
    run_job("after_rst", 2, 0, 32'hFFFFFFFF, 100);

    // Back-to-back: second start in the cycle right after DONE.
    run_job("b2b_a", 4, 0, 32'hFFFFFFFF, 100);
    run_job("b2b_b", 3, 0, 32'hFFFFFFFF, 100);

    for (int j = 0; j < 20; j++)
      run_job($sformatf("rnd%0d", j), $urandom_range(10), 1, '0, $urandom_range(100, 30));

    @(negedge clock);
    check("final idle", outs_now(), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
